// File: rtl/dm_pkg.sv
`timescale 1ns/1ps
// dm_pkg
//   Shared definitions for the dot matrix scan driver: default matrix
//   geometry, the scan state encoding and a row one-hot decoder.
package dm_pkg;

  localparam int DM_ROWS     = 8;
  localparam int DM_COLS     = 8;
  // Widest row vector the onehot helper can produce.
  localparam int DM_MAX_ROWS = 32;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } dm_state_e;

  function automatic logic [DM_MAX_ROWS-1:0] onehot(input logic [4:0] row);
    return DM_MAX_ROWS'(1) << row;
  endfunction

endpackage

// File: rtl/tick_sync.sv
`timescale 1ns/1ps
// tick_sync
//   Brings the divider's scan clock into the system clock domain and turns
//   each rising edge into a single-cycle pulse. The pulse is registered, so
//   it appears on the third clk edge after async_in rises.
// Ports
//   clk       in   system clock
//   rst       in   asynchronous reset, active-high
//   async_in  in   asynchronous level input
//   pulse_out out  one-cycle pulse per rising edge of async_in
module tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse_out
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta      <= 1'b0;
      sync      <= 1'b0;
      sync_d    <= 1'b0;
      pulse_out <= 1'b0;
    end else begin
      meta      <= async_in;
      sync      <= meta;
      sync_d    <= sync;
      pulse_out <= sync & ~sync_d;
    end
  end

endmodule

// File: rtl/dot_matrix_scanner.sv
`timescale 1ns/1ps
// dot_matrix_scanner
//   Row-multiplexed scan driver for an LED dot matrix. Each row is preceded
//   by a blanking gap (all rows off) and then lit for a fixed number of scan
//   ticks. Pixel data comes from a two-bank frame store: writes always go to
//   the back bank, and a requested swap takes effect at the next frame wrap.
// Ports
//   clk         in   system clock
//   rst         in   asynchronous reset, active-high
//   tick_in     in   scan clock from the divider, asynchronous level
//   wr_en       in   write one row word into the back bank
//   wr_row      in   row address for the write; values >= ROWS are ignored
//   wr_data     in   row pixels, bit i = column i, 1 = LED on
//   swap_req    in   one-cycle request to swap banks at the next frame wrap
//   swap_ack    out  high in the cycle whose clock edge performs the swap
//   row_sel     out  one-hot row enable, all zero while blanking
//   col_data    out  column drive for the selected row
//   frame_start out  one-cycle pulse when row 0 becomes lit
module dot_matrix_scanner
  import dm_pkg::*;
#(
  parameter int ROWS        = DM_ROWS,
  parameter int COLS        = DM_COLS,
  parameter int BLANK_TICKS = 1,
  parameter int ON_TICKS    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick_in,
  input  logic                     wr_en,
  input  logic [$clog2(ROWS):0]    wr_row,
  input  logic [COLS-1:0]          wr_data,
  input  logic                     swap_req,
  output logic                     swap_ack,
  output logic [ROWS-1:0]          row_sel,
  output logic [COLS-1:0]          col_data,
  output logic                     frame_start
);

  localparam int RW      = $clog2(ROWS);
  // The write address carries one extra bit so that addresses past the last
  // row are representable and can be rejected rather than aliasing.
  localparam int RA_W    = RW + 1;
  localparam int CNT_MAX = (BLANK_TICKS > ON_TICKS) ? BLANK_TICKS : ON_TICKS;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]   ON_LAST    = CW'(ON_TICKS - 1);
  localparam logic [CW-1:0]   BLANK_LAST = CW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
  localparam logic [RA_W-1:0] ROWS_A     = RA_W'(ROWS);

  dm_state_e       state, state_n;
  logic [RW-1:0]   row, row_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            front, front_n;
  logic            pending, pending_n;
  logic            load_col;
  logic            tick;

  logic [COLS-1:0] bank [0:1][0:ROWS-1];

  tick_sync u_tick_sync (
    .clk       (clk),
    .rst       (rst),
    .async_in  (tick_in),
    .pulse_out (tick)
  );

  // A request seen in the wrap cycle is kept as the new pending flag, so it
  // is served at the following wrap instead of being lost.
  always_comb begin
    state_n   = state;
    row_n     = row;
    cnt_n     = cnt;
    front_n   = front;
    pending_n = pending | swap_req;
    load_col  = 1'b0;
    swap_ack  = 1'b0;
    case (state)
      ST_BLANK: begin
        if (BLANK_TICKS == 0) begin
          state_n = ST_SHOW;
          cnt_n   = '0;
        end else if (tick) begin
          if (cnt == BLANK_LAST) begin
            state_n = ST_SHOW;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      ST_SHOW: begin
        if (tick) begin
          if (cnt == ON_LAST) begin
            state_n  = ST_BLANK;
            cnt_n    = '0;
            load_col = 1'b1;
            if (row == ROW_LAST) begin
              row_n = '0;
              if (pending) begin
                front_n   = ~front;
                swap_ack  = 1'b1;
                pending_n = swap_req;
              end
            end else begin
              row_n = row + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_BLANK;
      end
    endcase
  end

  // Row enables are registered from the next state so that only one bit can
  // change per edge and the blank gap always separates two lit rows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_BLANK;
      row         <= '0;
      cnt         <= '0;
      front       <= 1'b0;
      pending     <= 1'b0;
      row_sel     <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      row         <= row_n;
      cnt         <= cnt_n;
      front       <= front_n;
      pending     <= pending_n;
      row_sel     <= (state_n == ST_SHOW) ? ROWS'(onehot(5'(row_n))) : '0;
      frame_start <= (state == ST_BLANK) && (state_n == ST_SHOW) && (row_n == '0);
    end
  end

  // Writes target the bank that is currently in the back. In the wrap cycle
  // that is the bank about to become the front, so the data shows up in the
  // frame that starts there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          bank[b][r] <= '0;
        end
      end
    end else if (wr_en && (wr_row < ROWS_A)) begin
      bank[~front][wr_row[RW-1:0]] <= wr_data;
    end
  end

  // Column data is only reloaded when a blank gap begins, and it reads the
  // bank that will be in front after this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_data <= '0;
    end else if (load_col) begin
      col_data <= bank[front_n][row_n];
    end
  end

endmodule

// File: tb/tb_dot_matrix_scanner.sv
`timescale 1ns/1ps
// tb_dot_matrix_scanner
//   Drives the scanner with a software-generated scan clock, random writes
//   and swap requests, and compares every cycle against a tick-count model:
//   with k scan ticks seen since reset, the lit row is (k / 5) mod 8 and the
//   row is dark while k mod 5 is below the blank length.
module tb_dot_matrix_scanner;
  import dm_pkg::*;

  localparam int ROWS       = 8;
  localparam int COLS       = 8;
  localparam int BT         = 1;
  localparam int OT         = 4;
  localparam int RA_W       = $clog2(ROWS) + 1;
  localparam int ROW_PERIOD = BT + OT;
  localparam int FRAME      = ROWS * ROW_PERIOD;

  logic            clk;
  logic            rst;
  logic            tick_in;
  logic            wr_en;
  logic [RA_W-1:0] wr_row;
  logic [COLS-1:0] wr_data;
  logic            swap_req;
  logic            swap_ack;
  logic [ROWS-1:0] row_sel;
  logic [COLS-1:0] col_data;
  logic            frame_start;

  dot_matrix_scanner #(
    .ROWS        (ROWS),
    .COLS        (COLS),
    .BLANK_TICKS (BT),
    .ON_TICKS    (OT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_in     (tick_in),
    .wr_en       (wr_en),
    .wr_row      (wr_row),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .row_sel     (row_sel),
    .col_data    (col_data),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #12.5 clk = ~clk;

  // Reference model state.
  logic [COLS-1:0] mBank [2][ROWS];
  int              mFront;
  int              mPend;
  logic [COLS-1:0] mCol;
  int              k;
  int              kPrev;
  int              riseQ[$];
  logic            levelPrev;
  int              cyc;
  int              tickHalf;
  int              tickPhase;

  int total;
  int bad;
  int obsAck;
  int obsFs;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic int nextK();
    return k + ((riseQ.size() > 0 && riseQ[0] <= cyc - 3) ? 1 : 0);
  endfunction

  function automatic bit ackDue();
    int kn;
    kn = nextK();
    return (kn != k) && (kn % FRAME == 0) && (mPend != 0);
  endfunction

  task automatic modelReset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < ROWS; r++)
        mBank[b][r] = '0;
    mFront    = 0;
    mPend     = 0;
    mCol      = '0;
    k         = 0;
    kPrev     = 0;
    riseQ.delete();
    levelPrev = 1'b0;
    tickPhase = 0;
  endtask

  // Called at a falling edge: checks the current cycle, drives the inputs,
  // then advances the model across the next rising edge.
  task automatic applyStimulus(input logic wrEn, input logic [RA_W-1:0] wrRow,
                               input logic [COLS-1:0] wrData, input logic swapReq);
    int              kn;
    int              oldFront;
    logic            tickLvl;
    logic [ROWS-1:0] expSel;
    logic            expFs;
    logic            expAck;

    kn     = nextK();
    expSel = ((k % ROW_PERIOD) >= BT) ? (ROWS'(1) << ((k / ROW_PERIOD) % ROWS)) : '0;
    expFs  = (k != kPrev) && (k % FRAME == BT);
    expAck = ackDue();

    checkOutput("row_sel", 32'(row_sel), 32'(expSel));
    checkOutput("col_data", 32'(col_data), 32'(mCol));
    checkOutput("frame_start", 32'(frame_start), 32'(expFs));
    checkOutput("swap_ack", 32'(swap_ack), 32'(expAck));
    if (swap_ack === 1'b1) obsAck++;
    if (frame_start === 1'b1) obsFs++;

    tickLvl = tick_in;
    tickPhase++;
    if (tickPhase >= tickHalf) begin
      tickPhase = 0;
      tickLvl   = ~tick_in;
    end
    if (tickLvl && !levelPrev) riseQ.push_back(cyc);
    levelPrev = tickLvl;

    tick_in  = tickLvl;
    wr_en    = wrEn;
    wr_row   = wrRow;
    wr_data  = wrData;
    swap_req = swapReq;

    @(posedge clk);
    oldFront = mFront;
    if ((kn != k) && (kn % FRAME == 0) && (mPend != 0)) begin
      mFront = mFront ^ 1;
      mPend  = swapReq ? 1 : 0;
    end else if (swapReq) begin
      mPend = 1;
    end
    if ((kn != k) && (kn % ROW_PERIOD == 0))
      mCol = mBank[mFront][(kn / ROW_PERIOD) % ROWS];
    if (wrEn && wrRow < RA_W'(ROWS))
      mBank[oldFront ^ 1][wrRow] = wrData;
    if (riseQ.size() > 0 && riseQ[0] <= cyc - 3) void'(riseQ.pop_front());
    kPrev = k;
    k     = kn;
    cyc++;
    @(negedge clk);
  endtask

  task automatic runToTick(input int target, input string tag);
    int n;
    n = 0;
    while (k < target && n < 6000) begin
      applyStimulus(1'b0, '0, '0, 1'b0);
      n++;
    end
    if (k < target) checkOutput({"timeout_", tag}, 32'(k), 32'(target));
  endtask

  function automatic int midFrame();
    int m;
    m = (k / FRAME) * FRAME + FRAME / 2;
    if (m <= k) m += FRAME;
    return m;
  endfunction

  initial begin
    int   base;
    int   n;
    bit   found;

    total = 0; bad = 0; obsAck = 0; obsFs = 0; cyc = 0; tickHalf = 4;
    rst = 1'b1; tick_in = 1'b0; wr_en = 1'b0; wr_row = '0; wr_data = '0; swap_req = 1'b0;
    modelReset();

    // Reset held for 100 ns while the scan clock keeps running.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i % 2 == 1) tick_in = ~tick_in;
      checkOutput("rst_row_sel", 32'(row_sel), 32'h0);
      checkOutput("rst_col_data", 32'(col_data), 32'h0);
      checkOutput("rst_swap_ack", 32'(swap_ack), 32'h0);
      checkOutput("rst_frame_start", 32'(frame_start), 32'h0);
    end
    tick_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    modelReset();

    // Plain scanning over two frames.
    $display("[TB] scan order");
    obsFs = 0;
    runToTick(2 * FRAME + BT, "scan");
    checkOutput("frame_start_count", 32'(obsFs), 32'd2);

    // Fill the back bank, swap mid-frame.
    $display("[TB] data and swap");
    for (int r = 0; r < ROWS; r++)
      applyStimulus(1'b1, RA_W'(r), 8'(8'hA5 + r), 1'b0);
    obsAck = 0;
    runToTick(midFrame(), "mid_b");
    applyStimulus(1'b0, '0, '0, 1'b1);
    base = (k / FRAME + 1) * FRAME;
    runToTick(base + BT, "wrap_b");
    checkOutput("swap_row_sel", 32'(row_sel), 32'h01);
    checkOutput("swap_row0_data", 32'(col_data), 32'hA5);
    checkOutput("swap_ack_count", 32'(obsAck), 32'd1);

    // Two requests in one frame produce one swap.
    $display("[TB] double request");
    for (int r = 0; r < ROWS; r++)
      applyStimulus(1'b1, RA_W'(r), 8'(8'h50 + r), 1'b0);
    obsAck = 0;
    runToTick(midFrame(), "mid_c");
    applyStimulus(1'b0, '0, '0, 1'b1);
    runToTick(k + 10, "second_req");
    applyStimulus(1'b0, '0, '0, 1'b1);
    base = (k / FRAME + 1) * FRAME;
    runToTick(base + BT, "wrap_c1");
    checkOutput("dbl_row0_data", 32'(col_data), 32'h50);
    runToTick(base + FRAME + BT, "wrap_c2");
    checkOutput("dbl_row0_again", 32'(col_data), 32'h50);
    checkOutput("dbl_ack_count", 32'(obsAck), 32'd1);

    // Out-of-range write and a write landing in the swap cycle.
    $display("[TB] write edge cases");
    applyStimulus(1'b1, RA_W'(ROWS), 8'hFF, 1'b0);
    for (int r = 0; r < ROWS; r++)
      applyStimulus(1'b1, RA_W'(r), 8'(8'h10 + r), 1'b0);
    runToTick(midFrame(), "mid_d");
    applyStimulus(1'b0, '0, '0, 1'b1);
    found = 0;
    n = 0;
    while (!found && n < 2000) begin
      if (ackDue()) begin
        applyStimulus(1'b1, RA_W'(3), 8'h3C, 1'b0);
        found = 1;
      end else begin
        applyStimulus(1'b0, '0, '0, 1'b0);
      end
      n++;
    end
    if (!found) checkOutput("timeout_ack_d", 32'h0, 32'h1);
    base = (k / FRAME) * FRAME;
    runToTick(base + BT, "row0_d");
    checkOutput("wr_row8_ignored", 32'(col_data), 32'h10);
    runToTick(base + 3 * ROW_PERIOD + BT, "row3_d");
    checkOutput("swapcycle_row_sel", 32'(row_sel), 32'h08);
    checkOutput("swapcycle_write", 32'(col_data), 32'h3C);

    // Random traffic at varying scan rates.
    $display("[TB] random traffic");
    for (int seg = 0; seg < 4; seg++) begin
      tickHalf = $urandom_range(2, 6);
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 5) == 0)
          applyStimulus(1'b1, RA_W'($urandom_range(0, 9)), 8'($urandom), ($urandom_range(0, 199) == 0));
        else
          applyStimulus(1'b0, '0, '0, ($urandom_range(0, 199) == 0));
      end
    end

    // Reset while row 5 is lit.
    $display("[TB] reset mid-row");
    tickHalf = 4;
    n = 0;
    while (!(((k % ROW_PERIOD) >= BT) && ((k / ROW_PERIOD) % ROWS == 5)) && n < 3000) begin
      applyStimulus(1'b0, '0, '0, 1'b0);
      n++;
    end
    checkOutput("reach_row5", 32'(row_sel), 32'h20);
    #3 rst = 1'b1;
    #1;
    checkOutput("async_rst_row_sel", 32'(row_sel), 32'h0);
    checkOutput("async_rst_col_data", 32'(col_data), 32'h0);
    checkOutput("async_rst_frame_start", 32'(frame_start), 32'h0);
    @(negedge clk);
    tick_in = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    n = 0;
    while (row_sel == '0 && n < 200) begin
      applyStimulus(1'b0, '0, '0, 1'b0);
      n++;
    end
    checkOutput("first_row_after_rst", 32'(row_sel), 32'h01);
    runToTick(k + 2 * ROW_PERIOD, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
